ips2l_pcie_pll_recfg_v1_0: RTL and testbench

IPS2L_PCIE_PLL_RECFG_V1_0 -- requirements
Module: ips2l_pcie_pll_recfg_v1_0

---
 rtl/ips2l_pcie_pll_recfg_pkg.sv | 42 ++++
 rtl/ips2l_pcie_pll_recfg_if.sv | 26 ++
 rtl/ips2l_pcie_pll_lock_sync.sv | 25 ++
 rtl/ips2l_pcie_pll_recfg_v1_0.sv | 191 +++++++++++++++++++
 tb/tb_ips2l_pcie_pll_recfg_v1_0.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ips2l_pcie_pll_recfg_pkg.sv
// Shared definitions for the PCIe PLL reconfiguration controller.
//   - op_e      : command opcodes carried on req_op
//   - state_e   : controller FSM encodings
//   - *Def      : default values of the top-level parameters
//   - rmw_merge : read-modify-write merge, present only with PLL_RECFG_RMW_EN
// Optional feature macro: PLL_RECFG_RMW_EN (enables op 11 read-modify-write).
package ips2l_pcie_pll_recfg_pkg;

    localparam int unsigned RstCyclesDef   = 16;
    localparam int unsigned LockTimeoutDef = 65535;
    localparam int unsigned ApbTimeoutDef  = 255;
    // Wide enough for the largest LOCK_TIMEOUT.
    localparam int unsigned CntW           = 16;

    typedef enum logic [1:0] {
        OpRead   = 2'b00,
        OpWrite  = 2'b01,
        OpPllRst = 2'b10,
        OpRmw    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StSetup     = 3'd1,
        StAccess    = 3'd2,
`ifdef PLL_RECFG_RMW_EN
        StModify    = 3'd3,
`endif
        StRstAssert = 3'd4,
        StLockWait  = 3'd5,
        StResp      = 3'd6
    } state_e;

`ifdef PLL_RECFG_RMW_EN
    // Bits set in mask come from wdata, the rest keep the value read back.
    function automatic logic [15:0] rmw_merge(input logic [15:0] rd, input logic [15:0] wdata,
                                              input logic [15:0] mask);
        return (rd & ~mask) | (wdata & mask);
    endfunction
`endif

endpackage

// File: rtl/ips2l_pcie_pll_recfg_if.sv
// Command/response bus of the PLL reconfiguration controller.
//   master : requester (drives req_*, receives req_ready and rsp_*)
//   slave  : controller (receives req_*, drives req_ready and rsp_*)
interface ips2l_pcie_pll_recfg_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_addr;
    logic [15:0] req_wdata;
    logic [15:0] req_mask;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_mask,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_mask,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ips2l_pcie_pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the apb_clk domain.
//   clk      : destination clock
//   rst      : synchronous active-high reset
//   async_in : asynchronous lock input
//   sync_out : synchronized lock
module ips2l_pcie_pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], async_in};
        end
    end

    assign sync_out = sync_q[1];

endmodule

// File: rtl/ips2l_pcie_pll_recfg_v1_0.sv
// PCIe PLL reconfiguration controller: turns single commands into APB transfers to the PLL
// register port, or a PLL reset pulse followed by a bounded wait for lock.
//   apb_clk, rst         : clock and synchronous active-high reset
//   cmd (slave)          : req_valid/ready/op/addr/wdata/mask, rsp_valid/rdata/err
//   apb_sel/en/write/addr/wdata, apb_rdata/ready : APB master to the PLL
//   pll_rst, pll_lock, pll_locked : PLL reset output, async lock in, synchronized lock out
// Optional feature macro: PLL_RECFG_RMW_EN (op 11 = read-modify-write; otherwise an error).
module ips2l_pcie_pll_recfg_v1_0
    import ips2l_pcie_pll_recfg_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = RstCyclesDef,
    parameter int unsigned LOCK_TIMEOUT = LockTimeoutDef,
    parameter int unsigned APB_TIMEOUT  = ApbTimeoutDef
) (
    input  logic                         apb_clk,
    input  logic                         rst,
    ips2l_pcie_pll_recfg_if.slave        cmd,
    output logic                         apb_sel,
    output logic                         apb_en,
    output logic                         apb_write,
    output logic [4:0]                   apb_addr,
    output logic [15:0]                  apb_wdata,
    input  logic [15:0]                  apb_rdata,
    input  logic                         apb_ready,
    output logic                         pll_rst,
    input  logic                         pll_lock,
    output logic                         pll_locked
);

    localparam logic [CntW-1:0] RstLast  = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] LockLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] ApbLast  = CntW'(APB_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
`ifdef PLL_RECFG_RMW_EN
    logic              rmw_q, rmw_d;
    logic [15:0]       mask_q, mask_d;
`else
    logic              unused_mask;
    assign unused_mask = ^cmd.req_mask;
`endif

    ips2l_pcie_pll_lock_sync u_lock_sync (
        .clk      (apb_clk),
        .rst      (rst),
        .async_in (pll_lock),
        .sync_out (pll_locked)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        err_d   = err_q;
`ifdef PLL_RECFG_RMW_EN
        rmw_d   = rmw_q;
        mask_d  = mask_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd.req_valid) begin
                    addr_d  = cmd.req_addr;
                    wdata_d = cmd.req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    write_d = 1'b0;
                    cnt_d   = '0;
`ifdef PLL_RECFG_RMW_EN
                    rmw_d   = 1'b0;
                    mask_d  = cmd.req_mask;
`endif
                    unique case (op_e'(cmd.req_op))
                        OpRead:   state_d = StSetup;
                        OpWrite: begin
                            write_d = 1'b1;
                            state_d = StSetup;
                        end
                        OpPllRst: state_d = StRstAssert;
                        OpRmw: begin
`ifdef PLL_RECFG_RMW_EN
                            rmw_d   = 1'b1;
                            state_d = StSetup;
`else
                            err_d   = 1'b1;
                            state_d = StResp;
`endif
                        end
                    endcase
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (apb_ready) begin
                    // Only the read phase captures; an RMW keeps the pre-modify value.
                    if (!write_q) rdata_d = apb_rdata;
`ifdef PLL_RECFG_RMW_EN
                    state_d = (rmw_q && !write_q) ? StModify : StResp;
`else
                    state_d = StResp;
`endif
                end else if (cnt_q == ApbLast) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef PLL_RECFG_RMW_EN
            StModify: begin
                wdata_d = rmw_merge(rdata_q, wdata_q, mask_q);
                write_d = 1'b1;
                state_d = StSetup;
            end
`endif
            StRstAssert: begin
                if (cnt_q == RstLast) begin
                    cnt_d   = '0;
                    state_d = StLockWait;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StLockWait: begin
                // The counter keeps running across lock glitches.
                if (pll_locked) begin
                    state_d = StResp;
                end else if (cnt_q == LockLast) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge apb_clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef PLL_RECFG_RMW_EN
            rmw_q   <= 1'b0;
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            err_q   <= err_d;
`ifdef PLL_RECFG_RMW_EN
            rmw_q   <= rmw_d;
            mask_q  <= mask_d;
`endif
        end
    end

    assign apb_sel   = (state_q == StSetup) || (state_q == StAccess);
    assign apb_en    = (state_q == StAccess);
    assign apb_write = apb_sel & write_q;
    assign apb_addr  = apb_sel ? addr_q : '0;
    assign apb_wdata = apb_sel ? wdata_q : '0;
    assign pll_rst   = (state_q == StRstAssert);

    assign cmd.req_ready = (state_q == StIdle) && !rst;
    assign cmd.rsp_valid = (state_q == StResp);
    assign cmd.rsp_rdata = cmd.rsp_valid ? rdata_q : '0;
    assign cmd.rsp_err   = cmd.rsp_valid & err_q;

endmodule

// File: tb/tb_ips2l_pcie_pll_recfg_v1_0.sv
// Scoreboard bench: the driver computes each command's expected response from a memory
// model and pushes it; an independent monitor pops on every rsp_valid. An APB responder with
// programmable ready delay and a PLL model that locks a programmable time after release act
// as the PLL.
module tb_ips2l_pcie_pll_recfg_v1_0;

    localparam int RstCyc = 16;
    localparam int LockTo = 200;
    localparam int ApbTo  = 255;

    logic        apb_clk = 1'b0;
    logic        rst;
    logic        apb_sel, apb_en, apb_write;
    logic [4:0]  apb_addr;
    logic [15:0] apb_wdata;
    logic [15:0] apb_rdata = '0;
    logic        apb_ready = 1'b0;
    logic        pll_rst;
    logic        pll_lock = 1'b1;
    logic        pll_locked;

    ips2l_pcie_pll_recfg_if cmd_if ();

    ips2l_pcie_pll_recfg_v1_0 #(
        .RST_CYCLES   (RstCyc),
        .LOCK_TIMEOUT (LockTo),
        .APB_TIMEOUT  (ApbTo)
    ) dut (
        .apb_clk    (apb_clk),
        .rst        (rst),
        .cmd        (cmd_if.slave),
        .apb_sel    (apb_sel),
        .apb_en     (apb_en),
        .apb_write  (apb_write),
        .apb_addr   (apb_addr),
        .apb_wdata  (apb_wdata),
        .apb_rdata  (apb_rdata),
        .apb_ready  (apb_ready),
        .pll_rst    (pll_rst),
        .pll_lock   (pll_lock),
        .pll_locked (pll_locked)
    );

    always #5 apb_clk = ~apb_clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        got_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          cur_delay = 0;
    int          lock_delay = -1;
    int          sel_cycles = 0;
    bit          skip_width = 1'b0;
    logic [15:0] mem [32];
    logic [15:0] model_mem [32];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge apb_clk) begin
        cyc <= cyc + 1;
        if (apb_sel) sel_cycles <= sel_cycles + 1;
    end

    // APB responder: ready in ACCESS cycle number cur_delay (0-based).
    int acc_cnt = 0;
    always @(negedge apb_clk) begin
        if (apb_sel && apb_en) begin
            if (acc_cnt == cur_delay) begin
                apb_ready <= 1'b1;
                apb_rdata <= mem[apb_addr];
                if (apb_write) mem[apb_addr] <= apb_wdata;
            end else begin
                apb_ready <= 1'b0;
                apb_rdata <= 16'($urandom);
            end
            acc_cnt <= acc_cnt + 1;
        end else begin
            apb_ready <= 1'b0;
            apb_rdata <= 16'($urandom);
            acc_cnt   <= 0;
        end
    end

    // PLL: loses lock under reset, relocks lock_delay cycles after release (never if < 0).
    int since_rel = 1 << 20;
    always @(negedge apb_clk) begin
        if (pll_rst) begin
            pll_lock  <= 1'b0;
            since_rel <= 0;
        end else begin
            if (lock_delay >= 0 && since_rel == lock_delay) pll_lock <= 1'b1;
            if (since_rel < (1 << 20)) since_rel <= since_rel + 1;
        end
    end

    int rst_hi = 0;
    always @(negedge apb_clk) begin
        if (pll_rst) begin
            rst_hi <= rst_hi + 1;
        end else if (rst_hi != 0) begin
            if (!skip_width) check("pll_rst_width", rst_hi, RstCyc);
            rst_hi <= 0;
        end
    end

    // APB protocol: SETUP precedes ACCESS, controls stable, all zero when not selected.
    logic        p_sel = 1'b0, p_write = 1'b0;
    logic [4:0]  p_addr = '0;
    logic [15:0] p_wdata = '0;
    bit          p_ok = 1'b0;
    always @(negedge apb_clk) begin
        if (!rst && p_ok) begin
            if (apb_en) begin
                check("apb_setup_before_access", int'(p_sel), 1);
                check("apb_stable", int'({apb_write, apb_addr, apb_wdata} ==
                                         {p_write, p_addr, p_wdata}), 1);
            end
            if (!apb_sel) check("apb_idle_zero", int'({apb_en, apb_write, apb_addr, apb_wdata}), 0);
        end
        p_sel   <= apb_sel;
        p_write <= apb_write;
        p_addr  <= apb_addr;
        p_wdata <= apb_wdata;
        p_ok    <= !rst;
    end

    always @(negedge apb_clk) begin
        if (cmd_if.rsp_valid) begin
            check("rsp_apb_dropped", int'({apb_sel, apb_en}), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid, want none (cycle %0d)", cyc);
            end else begin
                got_e = exp_q.pop_front();
                check("rsp_rdata", int'(cmd_if.rsp_rdata), int'(got_e.rdata));
                check("rsp_err", int'(cmd_if.rsp_err), int'(got_e.err));
                if (got_e.lat >= 0) check("rsp_latency", cyc - got_e.acc, got_e.lat);
            end
        end
    end

    // Call at a negedge. push=0 issues a command that the caller will abort.
    task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] wd,
                         input logic [15:0] mk, input int dly, input int lk, input bit push);
        exp_t e;
        int   w;
        w = 0;
        while (!cmd_if.req_ready && w < 5000) begin
            @(negedge apb_clk);
            w++;
        end
        if (!cmd_if.req_ready) begin
            check("req_ready_timeout", 0, 1);
            return;
        end
        cur_delay  = dly;
        lock_delay = lk;
        e.rdata = '0;
        e.err   = 1'b0;
        e.lat   = -1;
        case (op)
            2'd0, 2'd1, 2'd3: begin
`ifndef PLL_RECFG_RMW_EN
                if (op == 2'd3) begin
                    e.err = 1'b1;
                    e.lat = 1;
                end else
`endif
                if (dly >= ApbTo) begin
                    e.err = 1'b1;
                    e.lat = 2 + ApbTo;
                end else if (op == 2'd0) begin
                    e.rdata = model_mem[addr];
                    e.lat   = 3 + dly;
                end else if (op == 2'd1) begin
                    if (push) model_mem[addr] = wd;
                    e.lat = 3 + dly;
                end else begin
                    e.rdata = model_mem[addr];
                    if (push) model_mem[addr] = (model_mem[addr] & ~mk) | (wd & mk);
                    e.lat = 6 + 2 * dly;
                end
            end
            default: begin
                if (lk < 0) begin
                    e.err = 1'b1;
                    e.lat = 1 + RstCyc + LockTo;
                end
            end
        endcase
        e.acc = cyc;
        if (push) exp_q.push_back(e);
        cmd_if.req_valid = 1'b1;
        cmd_if.req_op    = op;
        cmd_if.req_addr  = addr;
        cmd_if.req_wdata = wd;
        cmd_if.req_mask  = mk;
        @(negedge apb_clk);
        cmd_if.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || !cmd_if.req_ready) && w < 5000) begin
            @(negedge apb_clk);
            w++;
        end
        if (w >= 5000) check("response_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_for(input string name, input bit want_en);
        int w;
        w = 0;
        while (!(want_en ? apb_en : pll_rst) && w < 1000) begin
            @(negedge apb_clk);
            w++;
        end
        if (w >= 1000) check(name, 0, 1);
    endtask

    initial begin
        int r, sel_before, dly, lk;
        for (int i = 0; i < 32; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem[i]       = v;
            model_mem[i] = v;
        end
        mem[5'h0A] = 16'hBEEF; model_mem[5'h0A] = 16'hBEEF;
        mem[5'h05] = 16'hFF00; model_mem[5'h05] = 16'hFF00;
        rst = 1'b1;
        cmd_if.req_valid = 1'b0;
        cmd_if.req_op    = '0;
        cmd_if.req_addr  = '0;
        cmd_if.req_wdata = '0;
        cmd_if.req_mask  = '0;
        repeat (3) @(negedge apb_clk);
        check("reset_req_ready", int'(cmd_if.req_ready), 0);
        check("reset_outputs", int'({apb_sel, apb_en, pll_rst, cmd_if.rsp_valid, pll_locked}), 0);
        rst = 1'b0;
        @(negedge apb_clk);
        check("ready_after_reset", int'(cmd_if.req_ready), 1);

        issue(2'd1, 5'h03, 16'h1234, 16'h0000, 2, -1, 1'b1);
        issue(2'd0, 5'h03, 16'h0000, 16'h0000, 0, -1, 1'b1);
        issue(2'd0, 5'h0A, 16'h0000, 16'h0000, 0, -1, 1'b1);
        wait_done();
        sel_before = sel_cycles;
        issue(2'd3, 5'h05, 16'h00AA, 16'h00FF, 0, -1, 1'b1);
        wait_done();
`ifndef PLL_RECFG_RMW_EN
        check("no_apb_for_disabled_rmw", sel_cycles - sel_before, 0);
`endif
        issue(2'd0, 5'h05, 16'h0000, 16'h0000, 1, -1, 1'b1);
        issue(2'd2, 5'h00, 16'h0000, 16'h0000, 0, 100, 1'b1);
        issue(2'd2, 5'h00, 16'h0000, 16'h0000, 0, -1, 1'b1);
        issue(2'd0, 5'h11, 16'h0000, 16'h0000, 255, -1, 1'b1);
        issue(2'd1, 5'h12, 16'h5A5A, 16'h0000, 254, -1, 1'b1);
        issue(2'd0, 5'h12, 16'h0000, 16'h0000, 0, -1, 1'b1);
        wait_done();

        // Abort in ACCESS.
        issue(2'd0, 5'h07, 16'h0000, 16'h0000, 1000, -1, 1'b0);
        wait_for("reach_access", 1'b1);
        rst = 1'b1;
        @(negedge apb_clk);
        check("abort_access_outputs", int'({apb_sel, apb_en, pll_rst, cmd_if.rsp_valid}), 0);
        check("abort_access_ready", int'(cmd_if.req_ready), 0);
        rst = 1'b0;
        @(negedge apb_clk);
        check("abort_access_ready_back", int'(cmd_if.req_ready), 1);

        // Abort in RST_ASSERT.
        skip_width = 1'b1;
        issue(2'd2, 5'h00, 16'h0000, 16'h0000, 0, 10, 1'b0);
        wait_for("reach_rst_assert", 1'b0);
        repeat (3) @(negedge apb_clk);
        rst = 1'b1;
        @(negedge apb_clk);
        check("abort_rst_outputs", int'({apb_sel, apb_en, pll_rst, cmd_if.rsp_valid}), 0);
        rst = 1'b0;
        @(negedge apb_clk);
        check("abort_rst_ready_back", int'(cmd_if.req_ready), 1);
        repeat (5) @(negedge apb_clk);
        skip_width = 1'b0;

        for (int n = 0; n < 60; n++) begin
            r   = $urandom_range(0, 19);
            dly = (r < 17) ? $urandom_range(0, 4) : ((r == 17) ? 254 : ((r == 18) ? 255 : 400));
            lk  = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 150);
            issue(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 16'($urandom),
                  16'($urandom), dly, lk, 1'b1);
        end
        wait_done();
        repeat (3) @(negedge apb_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, want $finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
